// File: rtl/minsoc_clk_div_pkg.sv
// minsoc_clk_div_pkg: shared constants and helpers for the clock-enable divider bank.
//   DEF_NUM_CH / DEF_DIV_W / DEF_DEFAULT_DIV / DEF_LOCK_CYCLES : default parameter values.
//   eff_div() : maps a programmed divisor to the effective divide ratio (0 behaves as 1).
package minsoc_clk_div_pkg;

  localparam int unsigned DEF_NUM_CH      = 2;
  localparam int unsigned DEF_DIV_W       = 8;
  localparam int unsigned DEF_DEFAULT_DIV = 2;
  localparam int unsigned DEF_LOCK_CYCLES = 16;

  // A zero divisor would never reach terminal count; treat it as divide-by-one.
  function automatic int unsigned eff_div(input int unsigned div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/minsoc_clk_div_bank_if.sv
// minsoc_clk_div_bank_if: divisor-update handshake and clock-enable outputs of the divider bank.
//   div_wr  : per-channel single-cycle divisor write strobe
//   div_val : per-channel new divisor, channel k in bits [k*DIV_W +: DIV_W]
//   busy    : per-channel update pending
//   div_ack : per-channel one-cycle pulse when the new divisor takes effect
//   ce      : per-channel clock enable, one cycle per divide period
//   div_out : per-channel divided square wave
//   locked  : all channels stable
// master drives the writes; slave is the divider bank.
interface minsoc_clk_div_bank_if
  import minsoc_clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DIV_W  = DEF_DIV_W
);

  logic [NUM_CH-1:0]       div_wr;
  logic [NUM_CH*DIV_W-1:0] div_val;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       div_ack;
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH-1:0]       div_out;
  logic                    locked;

  modport master (
    output div_wr,
    output div_val,
    input  busy,
    input  div_ack,
    input  ce,
    input  div_out,
    input  locked
  );

  modport slave (
    input  div_wr,
    input  div_val,
    output busy,
    output div_ack,
    output ce,
    output div_out,
    output locked
  );

endinterface

// File: rtl/minsoc_clk_div_ch.sv
// minsoc_clk_div_ch: one divider channel (period counter, pending divisor, output decode).
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   wr_i, val_i    : divisor write strobe and value
//   align_i        : restart the counter at 0 (bank-wide phase alignment; tied 0 when unused)
//   apply_o        : this channel applies its pending divisor at the end of this cycle
//   busy_o, ack_o  : update pending / new divisor in effect this cycle
//   ce_o, div_o    : clock enable and divided square wave, decoded from registers only
module minsoc_clk_div_ch
  import minsoc_clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] val_i,
  input  logic             align_i,
  output logic             apply_o,
  output logic             busy_o,
  output logic             ack_o,
  output logic             ce_o,
  output logic             div_o
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pend;
  logic             r_busy;
  logic             r_ack;

  logic [DIV_W-1:0] w_last;
  logic [DIV_W-1:0] w_half;
  logic             w_tc;
  logic             w_apply;

  always_comb begin
    w_last  = DIV_W'(eff_div(32'(r_div)) - 32'd1);
    // Odd ratios put the extra cycle in the high phase.
    w_half  = DIV_W'(eff_div(32'(r_div)) >> 1);
    w_tc    = (r_cnt == w_last);
    w_apply = w_tc & r_busy;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt  <= '0;
      r_div  <= DIV_W'(DEFAULT_DIV);
      r_pend <= '0;
      r_busy <= 1'b0;
      r_ack  <= 1'b0;
    end else begin
      r_ack <= w_apply;
      if (w_apply) begin
        r_div <= r_pend;
      end
      // Applying only at terminal count means no partial period is ever emitted.
      if (w_tc || align_i) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
      // A write coinciding with an apply wins: it is held for the next terminal count.
      if (wr_i) begin
        r_pend <= val_i;
        r_busy <= 1'b1;
      end else if (w_apply) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign apply_o = w_apply;
  assign busy_o  = r_busy;
  assign ack_o   = r_ack;
  assign ce_o    = w_tc;
  assign div_o   = (r_cnt >= w_half);

endmodule

// File: rtl/minsoc_clk_div_bank.sv
// minsoc_clk_div_bank: multi-channel runtime-programmable clock-enable generator.
//   clk_i   : system clock
//   rst_n_i : asynchronous active-low reset
//   bus     : minsoc_clk_div_bank_if.slave (div_wr, div_val, busy, div_ack, ce, div_out, locked)
// Optional feature macro MINSOC_CLKDIV_PHASE_ALIGN_EN: when defined, any channel applying a new
// divisor restarts every channel's counter in the same cycle so all channels are phase aligned.
module minsoc_clk_div_bank
  import minsoc_clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  minsoc_clk_div_bank_if.slave bus
);

  localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);

  logic [NUM_CH-1:0] w_apply;
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_ack;
  logic [NUM_CH-1:0] w_ce;
  logic [NUM_CH-1:0] w_div;
  logic              w_align;
  logic              w_quiet;
  logic [LockW-1:0]  r_lock_cnt;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    minsoc_clk_div_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .wr_i    (bus.div_wr[k]),
      .val_i   (bus.div_val[k*DIV_W +: DIV_W]),
      .align_i (w_align),
      .apply_o (w_apply[k]),
      .busy_o  (w_busy[k]),
      .ack_o   (w_ack[k]),
      .ce_o    (w_ce[k]),
      .div_o   (w_div[k])
    );
  end

`ifdef MINSOC_CLKDIV_PHASE_ALIGN_EN
  assign w_align = |w_apply;
`else
  logic w_unused_apply;
  assign w_unused_apply = |w_apply;
  assign w_align        = 1'b0;
`endif

  assign bus.busy    = w_busy;
  assign bus.div_ack = w_ack;
  assign bus.ce      = w_ce;
  assign bus.div_out = w_div;

  // Quiet-cycle counter: any write restarts it; it saturates at LOCK_CYCLES.
  assign w_quiet = ~|{w_busy, bus.div_wr};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lock_cnt <= '0;
    end else if (|bus.div_wr) begin
      r_lock_cnt <= '0;
    end else if (w_quiet && (r_lock_cnt != LockW'(LOCK_CYCLES))) begin
      r_lock_cnt <= r_lock_cnt + LockW'(1);
    end
  end

  assign bus.locked = (r_lock_cnt == LockW'(LOCK_CYCLES));

endmodule

// File: tb/tb_minsoc_clk_div_bank.sv
module tb_minsoc_clk_div_bank;

  localparam int NumCh   = 2;
  localparam int DivW    = 8;
  localparam int DefDiv  = 2;
  localparam int LockCyc = 16;

`ifdef MINSOC_CLKDIV_PHASE_ALIGN_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  minsoc_clk_div_bank_if #(.NUM_CH(NumCh), .DIV_W(DivW)) bus ();

  minsoc_clk_div_bank #(
    .NUM_CH      (NumCh),
    .DIV_W       (DivW),
    .DEFAULT_DIV (DefDiv),
    .LOCK_CYCLES (LockCyc)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int t;  // cycle index since the last reset release

  // Divisor timeline: t is the first cycle the divisor is in effect (counter at 0).
  typedef struct {
    int t;
    int ch;
    int d;
    bit ack;
  } ev_t;
  ev_t ev[$];

  typedef struct {
    int                t;
    logic [NumCh-1:0] ce;
    logic [NumCh-1:0] dv;
    logic [NumCh-1:0] ack;
  } exp_t;
  exp_t sb[$];

  function automatic int m_div(input int ch, input int tt);
    int d = DefDiv;
    foreach (ev[i]) if (ev[i].ch == ch && ev[i].t <= tt) d = ev[i].d;
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int m_org(input int ch, input int tt);
    int o = 0;
    foreach (ev[i]) if (ev[i].t <= tt && (ev[i].ch == ch || AlignEn)) o = ev[i].t;
    return o;
  endfunction

  function automatic int m_ph(input int ch, input int tt);
    return (tt - m_org(ch, tt)) % m_div(ch, tt);
  endfunction

  function automatic bit m_ack(input int ch, input int tt);
    bit a = 1'b0;
    foreach (ev[i]) if (ev[i].ch == ch && ev[i].t == tt && ev[i].ack) a = 1'b1;
    return a;
  endfunction

  function automatic int m_next_tc(input int ch, input int from);
    int tt = from;
    while (m_ph(ch, tt) != m_div(ch, tt) - 1) tt++;
    return tt;
  endfunction

  task automatic model_reset();
    ev.delete();
    for (int c = 0; c < NumCh; c++) ev.push_back('{t: 0, ch: c, d: DefDiv, ack: 1'b0});
  endtask

  task automatic push_window(input int from, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.t = from + k;
      for (int c = 0; c < NumCh; c++) begin
        int d;
        int p;
        d = m_div(c, from + k);
        p = m_ph(c, from + k);
        e.ce[c]  = (p == d - 1);
        e.dv[c]  = (p >= d / 2);
        e.ack[c] = m_ack(c, from + k);
      end
      sb.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n       = 1'b0;
    bus.div_wr  = '0;
    bus.div_val = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.ce, bus.div_out, bus.div_ack, bus.busy, bus.locked} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_hold ce=%b div=%b ack=%b busy=%b lock=%b required all 0",
               bus.ce, bus.div_out, bus.div_ack, bus.busy, bus.locked);
    end
    rst_n = 1'b1;
    t     = 0;
    model_reset();
    push_window(0, 20);
    for (int j = 0; j < 20; j++) begin
      e = sb.pop_front();
      n_tests++;
      if (bus.ce !== e.ce || bus.div_out !== e.dv || bus.div_ack !== e.ack) begin
        n_fail++;
        $display("FAIL reset_run t=%0d ce=%b/%b div=%b/%b ack=%b/%b", t, bus.ce, e.ce,
                 bus.div_out, e.dv, bus.div_ack, e.ack);
      end
      n_tests++;
      if (bus.locked !== (t >= LockCyc) || bus.busy !== '0) begin
        n_fail++;
        $display("FAIL lock_rise t=%0d locked=%b required %b busy=%b", t, bus.locked,
                 (t >= LockCyc), bus.busy);
      end
      step();
    end
  endtask

  task automatic test_update();
    exp_t e;
    int   t0, a, lock_old, lock_new;
    for (int g = 0; g < 300 && m_ph(0, t) != 0; g++) step();
    t0       = t;
    a        = m_next_tc(0, t0 + 1) + 1;
    lock_old = LockCyc;
    lock_new = a + LockCyc;
    ev.push_back('{t: a, ch: 0, d: 5, ack: 1'b1});
    push_window(t0, 24);
    for (int j = 0; j < 24; j++) begin
      e = sb.pop_front();
      n_tests++;
      if (bus.ce !== e.ce || bus.div_out !== e.dv || bus.div_ack !== e.ack) begin
        n_fail++;
        $display("FAIL update5 t=%0d ce=%b/%b div=%b/%b ack=%b/%b", t, bus.ce, e.ce,
                 bus.div_out, e.dv, bus.div_ack, e.ack);
      end
      n_tests++;
      if (bus.busy !== {1'b0, (t > t0 && t < a)} ||
          bus.locked !== ((t <= t0) ? (t >= lock_old) : (t >= lock_new))) begin
        n_fail++;
        $display("FAIL update5_status t=%0d busy=%b locked=%b", t, bus.busy, bus.locked);
      end
      bus.div_wr  = (t == t0) ? 2'b01 : 2'b00;
      bus.div_val = {8'd0, 8'd5};
      step();
    end
    bus.div_wr = '0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   t0, a, lock_old, lock_new;
    lock_old = m_org(0, t) + LockCyc;
    foreach (ev[i]) if (ev[i].ack) lock_old = ev[i].t + LockCyc;
    // Start on a terminal count while idle: that write must wait for the next one.
    for (int g = 0; g < 300 && m_ph(1, t) != m_div(1, t) - 1; g++) step();
    t0       = t;
    a        = m_next_tc(1, t0 + 2) + 1;
    lock_new = a + LockCyc;
    ev.push_back('{t: a, ch: 1, d: 7, ack: 1'b1});
    push_window(t0, 24);
    for (int j = 0; j < 24; j++) begin
      e = sb.pop_front();
      n_tests++;
      if (bus.ce !== e.ce || bus.div_out !== e.dv || bus.div_ack !== e.ack) begin
        n_fail++;
        $display("FAIL b2b t=%0d ce=%b/%b div=%b/%b ack=%b/%b", t, bus.ce, e.ce,
                 bus.div_out, e.dv, bus.div_ack, e.ack);
      end
      n_tests++;
      if (bus.busy !== {(t > t0 && t < a), 1'b0} ||
          bus.locked !== ((t <= t0) ? (t >= lock_old) : (t >= lock_new))) begin
        n_fail++;
        $display("FAIL b2b_status t=%0d busy=%b locked=%b", t, bus.busy, bus.locked);
      end
      bus.div_wr  = (t == t0 || t == t0 + 1) ? 2'b10 : 2'b00;
      bus.div_val = (t == t0) ? {8'd3, 8'd0} : {8'd7, 8'd0};
      step();
    end
    bus.div_wr = '0;
  endtask

  task automatic test_div_zero_one();
    exp_t e;
    int   t0, a, t1, a2, n;
    for (int g = 0; g < 300 && m_ph(0, t) == m_div(0, t) - 1; g++) step();
    t0 = t;
    a  = m_next_tc(0, t0 + 1) + 1;
    t1 = a + 3;
    a2 = t1 + 2;
    ev.push_back('{t: a, ch: 0, d: 0, ack: 1'b1});
    ev.push_back('{t: a2, ch: 0, d: 1, ack: 1'b1});
    n = a2 - t0 + 6;
    push_window(t0, n);
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      n_tests++;
      if (bus.ce !== e.ce || bus.div_out !== e.dv || bus.div_ack !== e.ack) begin
        n_fail++;
        $display("FAIL div0_div1 t=%0d ce=%b/%b div=%b/%b ack=%b/%b", t, bus.ce, e.ce,
                 bus.div_out, e.dv, bus.div_ack, e.ack);
      end
      n_tests++;
      if (bus.busy[0] !== ((t > t0 && t < a) || (t > t1 && t < a2)) ||
          (t > t0 && bus.locked !== 1'b0)) begin
        n_fail++;
        $display("FAIL div0_div1_status t=%0d busy=%b locked=%b", t, bus.busy, bus.locked);
      end
      bus.div_wr  = (t == t0 || t == t1) ? 2'b01 : 2'b00;
      bus.div_val = (t == t0) ? {8'd0, 8'd0} : {8'd0, 8'd1};
      step();
    end
    bus.div_wr = '0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   t0;
    for (int g = 0; g < 300 && m_ph(1, t) == m_div(1, t) - 1; g++) step();
    t0          = t;
    bus.div_wr  = 2'b10;
    bus.div_val = {8'd9, 8'd0};
    step();
    bus.div_wr = '0;
    n_tests++;
    if (bus.busy !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_busy t=%0d busy=%b required 10", t, bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.ce, bus.div_out, bus.div_ack, bus.busy, bus.locked} !== 9'd0) begin
      n_fail++;
      $display("FAIL async_reset ce=%b div=%b ack=%b busy=%b lock=%b required all 0",
               bus.ce, bus.div_out, bus.div_ack, bus.busy, bus.locked);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t     = 0;
    model_reset();
    push_window(0, 12);
    for (int j = 0; j < 12; j++) begin
      e = sb.pop_front();
      n_tests++;
      if (bus.ce !== e.ce || bus.div_out !== e.dv || bus.div_ack !== e.ack ||
          bus.busy !== '0 || bus.locked !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset t=%0d ce=%b/%b div=%b/%b ack=%b/%b busy=%b locked=%b", t,
                 bus.ce, e.ce, bus.div_out, e.dv, bus.div_ack, e.ack, bus.busy, bus.locked);
      end
      step();
    end
    if (t0 < 0) $display("note: unexpected start cycle %0d", t0);
  endtask

  task automatic test_align();
    exp_t e;
    int   t0, a, t1, a2, n;
    for (int g = 0; g < 300 && m_ph(0, t) != 0; g++) step();
    t0 = t;
    a  = m_next_tc(0, t0 + 1) + 1;
    ev.push_back('{t: a, ch: 0, d: 3, ack: 1'b1});
    ev.push_back('{t: a, ch: 1, d: 4, ack: 1'b1});
    t1 = a;
    a2 = m_next_tc(0, t1 + 1) + 1;
    ev.push_back('{t: a2, ch: 0, d: 6, ack: 1'b1});
    n = a2 - t0 + 14;
    push_window(t0, n);
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      n_tests++;
      if (bus.ce !== e.ce || bus.div_out !== e.dv || bus.div_ack !== e.ack) begin
        n_fail++;
        $display("FAIL align t=%0d ce=%b/%b div=%b/%b ack=%b/%b", t, bus.ce, e.ce,
                 bus.div_out, e.dv, bus.div_ack, e.ack);
      end
      n_tests++;
      if (bus.busy !== {(t > t0 && t < a), ((t > t0 && t < a) || (t > t1 && t < a2))} ||
          bus.locked !== 1'b0) begin
        n_fail++;
        $display("FAIL align_status t=%0d busy=%b locked=%b", t, bus.busy, bus.locked);
      end
      bus.div_wr  = (t == t0) ? 2'b11 : ((t == t1) ? 2'b01 : 2'b00);
      bus.div_val = (t == t0) ? {8'd4, 8'd3} : {8'd0, 8'd6};
      step();
    end
    bus.div_wr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_update();
    test_back_to_back();
    test_div_zero_one();
    test_reset_mid();
    test_align();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
